// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 AR/R channel pair between instruction fetch (port 0) and the LSU (port 1).
// One single-beat 64-bit read is in flight at a time. Each requester gets a one-cycle response pulse.
module axi_rd_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  input  logic        if_flush,
  output logic        if_resp_valid,
  input  logic        ls_req_valid,
  input  logic [31:0] ls_req_addr,
  output logic        ls_req_ready,
  output logic        ls_resp_valid,
  output logic [63:0] resp_data,
  output logic        resp_err,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic [31:0] axi_araddr,
  output logic        axi_arid,
  output logic [7:0]  axi_arlen,
  output logic [2:0]  axi_arsize,
  output logic [1:0]  axi_arburst,
  input  logic        axi_rvalid,
  input  logic [63:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rlast,
  input  logic        axi_rid,
  output logic        axi_rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_gnt_q, last_gnt_d;
  logic        drop_q, drop_d;
  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        if_resp_q, if_resp_d;
  logic        ls_resp_q, ls_resp_d;
  logic [63:0] data_q, data_d;
  logic        err_q, err_d;

  logic        gnt_if_s;
  logic        gnt_ls_s;
  logic        drop_hit_s;
  logic        unused_s;

  // A fetch flush seen at any point while the fetch owns the channel discards its response
  assign drop_hit_s = drop_q | (if_flush & ~owner_q);

  // Choose at most one winner while idle; ties go to whoever was not served last, or always the LSU
  always_comb begin
    gnt_if_s = 1'b0;
    gnt_ls_s = 1'b0;
    if (state_q != IDLE) begin
      gnt_if_s = 1'b0;
      gnt_ls_s = 1'b0;
    end else if (if_req_valid && ls_req_valid) begin
      if ((RR_EN == 1'b1) && (last_gnt_q == 1'b1)) begin
        gnt_if_s = 1'b1;
      end else begin
        gnt_ls_s = 1'b1;
      end
    end else begin
      gnt_if_s = if_req_valid;
      gnt_ls_s = ls_req_valid;
    end
  end

  // Next-state and next-output computation for the IDLE/ADDR/DATA sequencer
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    drop_d     = drop_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    if_resp_d  = 1'b0;
    ls_resp_d  = 1'b0;
    data_d     = data_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (gnt_if_s || gnt_ls_s) begin
          owner_d    = gnt_ls_s;
          last_gnt_d = gnt_ls_s;
          araddr_d   = gnt_ls_s ? {ls_req_addr[31:3], 3'b000} : {if_req_addr[31:3], 3'b000};
          arvalid_d  = 1'b1;
          state_d    = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        drop_d = drop_hit_s;
        if (axi_arready) begin
          arvalid_d = 1'b0;
          araddr_d  = 32'd0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (axi_rvalid) begin
          rready_d  = 1'b0;
          data_d    = axi_rdata;
          err_d     = (axi_rresp != 2'b00);
          if_resp_d = ~owner_q & ~drop_hit_s;
          ls_resp_d = owner_q;
          drop_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          drop_d  = drop_hit_s;
          state_d = DATA;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        araddr_d  = 32'd0;
        rready_d  = 1'b0;
        drop_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b0;
      drop_q     <= 1'b0;
      araddr_q   <= 32'd0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      if_resp_q  <= 1'b0;
      ls_resp_q  <= 1'b0;
      data_q     <= 64'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      drop_q     <= drop_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      if_resp_q  <= if_resp_d;
      ls_resp_q  <= ls_resp_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign if_req_ready  = gnt_if_s;
  assign ls_req_ready  = gnt_ls_s;
  assign if_resp_valid = if_resp_q;
  assign ls_resp_valid = ls_resp_q;
  assign resp_data     = data_q;
  assign resp_err      = err_q;
  assign axi_arvalid   = arvalid_q;
  assign axi_araddr    = araddr_q;
  assign axi_arid      = owner_q;
  assign axi_arlen     = 8'd0;
  assign axi_arsize    = 3'd3;
  assign axi_arburst   = 2'b01;
  assign axi_rready    = rready_q;

  // Only one read is ever in flight, so the beat markers and low address bits carry no information
  assign unused_s = ^{axi_rlast, axi_rid, if_req_addr[2:0], ls_req_addr[2:0]};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus random traffic. A transaction-level model
// predicts grants, AR/R handshakes and response pulses, and every output is checked against it each cycle.
module tb_axi_rd_arbiter;

  localparam bit RR_EN = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req_valid, if_flush, ls_req_valid;
  logic [31:0] if_req_addr, ls_req_addr;
  logic        axi_arready, axi_rvalid, axi_rlast, axi_rid;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;

  wire         if_req_ready, if_resp_valid, ls_req_ready, ls_resp_valid, resp_err;
  wire [63:0]  resp_data;
  wire         axi_arvalid, axi_arid, axi_rready;
  wire [31:0]  axi_araddr;
  wire [7:0]   axi_arlen;
  wire [2:0]   axi_arsize;
  wire [1:0]   axi_arburst;

  wire         fp_if_req_ready, fp_ls_req_ready, fp_axi_arvalid, fp_axi_arid;
  wire         fp_unused_if_resp_valid, fp_unused_ls_resp_valid, fp_unused_resp_err, fp_unused_rready;
  wire [63:0]  fp_unused_resp_data;
  wire [31:0]  fp_unused_araddr;
  wire [7:0]   fp_unused_arlen;
  wire [2:0]   fp_unused_arsize;
  wire [1:0]   fp_unused_arburst;

  axi_rd_arbiter #(.RR_EN(RR_EN)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_resp_valid(if_resp_valid),
    .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rid(axi_rid), .axi_rready(axi_rready)
  );

  // Fixed-priority instance on the same stimulus, only examined during the tie scenario
  axi_rd_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(fp_if_req_ready),
    .if_flush(if_flush), .if_resp_valid(fp_unused_if_resp_valid),
    .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_ready(fp_ls_req_ready),
    .ls_resp_valid(fp_unused_ls_resp_valid), .resp_data(fp_unused_resp_data), .resp_err(fp_unused_resp_err),
    .axi_arvalid(fp_axi_arvalid), .axi_arready(axi_arready), .axi_araddr(fp_unused_araddr),
    .axi_arid(fp_axi_arid), .axi_arlen(fp_unused_arlen), .axi_arsize(fp_unused_arsize),
    .axi_arburst(fp_unused_arburst),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rid(axi_rid), .axi_rready(fp_unused_rready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the channel, whether AR is done, what pulse is due next
  logic        m_busy, m_owner, m_ardone, m_drop, m_last, m_exp_if, m_exp_ls, m_err;
  logic [31:0] m_addr;
  logic [63:0] m_data;
  logic        w_if, w_ls;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst if_req_ready", 64'(if_req_ready), 64'd0);
      chk("rst ls_req_ready", 64'(ls_req_ready), 64'd0);
      chk("rst if_resp_valid", 64'(if_resp_valid), 64'd0);
      chk("rst ls_resp_valid", 64'(ls_resp_valid), 64'd0);
      chk("rst resp_err", 64'(resp_err), 64'd0);
      chk("rst resp_data", resp_data, 64'd0);
      chk("rst arvalid", 64'(axi_arvalid), 64'd0);
      chk("rst araddr", 64'(axi_araddr), 64'd0);
      chk("rst arid", 64'(axi_arid), 64'd0);
      chk("rst rready", 64'(axi_rready), 64'd0);
      m_busy = 1'b0; m_owner = 1'b0; m_ardone = 1'b0; m_drop = 1'b0; m_last = 1'b0;
      m_exp_if = 1'b0; m_exp_ls = 1'b0; m_err = 1'b0; m_addr = 32'd0; m_data = 64'd0;
    end else begin
      chk("if_resp_valid", 64'(if_resp_valid), 64'(m_exp_if));
      chk("ls_resp_valid", 64'(ls_resp_valid), 64'(m_exp_ls));
      chk("resp_data", resp_data, m_data);
      chk("resp_err", 64'(resp_err), 64'(m_err));
      w_ls = !m_busy && ls_req_valid && (!if_req_valid || (RR_EN == 1'b0) || (m_last == 1'b0));
      w_if = !m_busy && if_req_valid && !w_ls;
      chk("if_req_ready", 64'(if_req_ready), 64'(w_if));
      chk("ls_req_ready", 64'(ls_req_ready), 64'(w_ls));
      chk("arvalid", 64'(axi_arvalid), 64'(m_busy && !m_ardone));
      chk("rready", 64'(axi_rready), 64'(m_busy && m_ardone));
      if (m_busy && !m_ardone) begin
        chk("araddr", 64'(axi_araddr), 64'(m_addr));
        chk("arid", 64'(axi_arid), 64'(m_owner));
        chk("arlen", 64'(axi_arlen), 64'd0);
        chk("arsize", 64'(axi_arsize), 64'd3);
        chk("arburst", 64'(axi_arburst), 64'd1);
      end else begin
        chk("araddr idle", 64'(axi_araddr), 64'd0);
      end
      m_exp_if = 1'b0;
      m_exp_ls = 1'b0;
      if (m_busy) begin
        if (!m_owner && if_flush) m_drop = 1'b1;
        if (!m_ardone) begin
          if (axi_arready) m_ardone = 1'b1;
        end else if (axi_rvalid) begin
          m_busy   = 1'b0;
          m_data   = axi_rdata;
          m_err    = (axi_rresp != 2'b00);
          m_exp_if = !m_owner && !m_drop;
          m_exp_ls = m_owner;
        end
      end else if (w_if || w_ls) begin
        m_busy   = 1'b1;
        m_owner  = w_ls;
        m_last   = w_ls;
        m_addr   = (w_ls ? ls_req_addr : if_req_addr) & 32'hFFFF_FFF8;
        m_ardone = 1'b0;
        m_drop   = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: run did not complete, limit 500000 time units");
    $fatal(1, "timeout");
  end

  task automatic cyc; @(posedge clk); #1; endtask
  task automatic smp; @(negedge clk); endtask

  int          g_seq[$];
  int          id_seq[$];
  int          exp_alt[4] = '{1, 0, 1, 0};
  bit          s_pend;
  int unsigned s_wait;
  int          n_resp;

  initial begin
    rst_n = 1'b0; if_req_valid = 1'b0; ls_req_valid = 1'b0; if_flush = 1'b0;
    if_req_addr = 32'd0; ls_req_addr = 32'd0; axi_arready = 1'b0; axi_rvalid = 1'b0;
    axi_rdata = 64'd0; axi_rresp = 2'b00; axi_rlast = 1'b1; axi_rid = 1'b0;
    s_pend = 1'b0; s_wait = 0; n_resp = 0;
    repeat (3) cyc;
    smp; chk("reset arvalid literal", 64'(axi_arvalid), 64'd0);
    cyc; rst_n = 1'b1;

    // Fetch only, zero-stall slave
    cyc; if_req_valid = 1'b1; if_req_addr = 32'h0000_1004; axi_arready = 1'b1;
    smp; chk("fetch accept T", 64'(if_req_ready), 64'd1);
    cyc; if_req_valid = 1'b0;
    smp; chk("fetch araddr T+1", 64'(axi_araddr), 64'h1000);
         chk("fetch arid T+1", 64'(axi_arid), 64'd0);
    cyc; axi_arready = 1'b0; axi_rvalid = 1'b1; axi_rdata = 64'hDEAD_BEEF_0123_4567;
    smp; chk("fetch rready T+2", 64'(axi_rready), 64'd1);
    cyc; axi_rvalid = 1'b0;
    smp; chk("fetch resp T+3", 64'(if_resp_valid), 64'd1);
         chk("fetch data T+3", resp_data, 64'hDEAD_BEEF_0123_4567);
         chk("fetch err T+3", 64'(resp_err), 64'd0);

    // Both requesters held valid: round-robin alternates, fixed priority keeps the LSU
    for (int i = 0; i < 12; i++) begin
      cyc;
      if (i == 0) begin
        if_req_valid = 1'b1; ls_req_valid = 1'b1; if_req_addr = 32'h0000_3010;
        ls_req_addr = 32'h8000_0020; axi_arready = 1'b1; axi_rvalid = 1'b1;
        axi_rdata = 64'h1111_2222_3333_4444;
      end
      if (i == 10) begin if_req_valid = 1'b0; ls_req_valid = 1'b0; end
      smp;
      if (if_req_ready || ls_req_ready) begin
        g_seq.push_back(int'(ls_req_ready));
        chk("fixed-prio tie ls", 64'(fp_ls_req_ready), 64'd1);
        chk("fixed-prio tie if", 64'(fp_if_req_ready), 64'd0);
      end
      if (axi_arvalid) id_seq.push_back(int'(axi_arid));
      if (fp_axi_arvalid) chk("fixed-prio arid", 64'(fp_axi_arid), 64'd1);
    end
    cyc; axi_arready = 1'b0; axi_rvalid = 1'b0;
    chk("tie grant count", 64'(g_seq.size()), 64'd4);
    chk("tie arid count", 64'(id_seq.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < g_seq.size()) chk("tie grant order", 64'(g_seq[k]), 64'(exp_alt[k]));
      if (k < id_seq.size()) chk("tie arid order", 64'(id_seq[k]), 64'(exp_alt[k]));
    end

    // AR stalled 5 cycles, R stalled 3; LSU waits and is then served with an error response
    cyc; if_req_valid = 1'b1; if_req_addr = 32'h0000_2A2C;
    smp; chk("stall accept T", 64'(if_req_ready), 64'd1);
    cyc; if_req_valid = 1'b0; ls_req_valid = 1'b1; ls_req_addr = 32'h0000_4444;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) cyc;
      smp;
      chk("stall arvalid", 64'(axi_arvalid), 64'd1);
      chk("stall araddr", 64'(axi_araddr), 64'h2A28);
      chk("stall no ls ready", 64'(ls_req_ready), 64'd0);
    end
    cyc; axi_arready = 1'b1;
    smp; chk("stall arvalid T+6", 64'(axi_arvalid), 64'd1);
    cyc; axi_arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) cyc;
      smp;
      chk("stall rready", 64'(axi_rready), 64'd1);
      chk("stall no ls ready R", 64'(ls_req_ready), 64'd0);
    end
    cyc; axi_rvalid = 1'b1; axi_rdata = 64'h0BAD_F00D_5555_AAAA;
    smp; chk("stall R handshake T+10", 64'(axi_rready), 64'd1);
    cyc; axi_rvalid = 1'b0;
    smp; chk("stall resp T+11", 64'(if_resp_valid), 64'd1);
         chk("ls accepted after stall", 64'(ls_req_ready), 64'd1);
    cyc; ls_req_valid = 1'b0; axi_arready = 1'b1;
    smp; chk("ls arid", 64'(axi_arid), 64'd1);
    cyc; axi_arready = 1'b0; axi_rvalid = 1'b1; axi_rresp = 2'b10; axi_rdata = 64'hCAFE_0000_0000_0001;
    cyc; axi_rvalid = 1'b0; axi_rresp = 2'b00;
    smp; chk("ls err resp", 64'(ls_resp_valid), 64'd1);
         chk("ls err flag", 64'(resp_err), 64'd1);

    // Flush during DATA: handshake completes, pulse suppressed, LSU accepted in the next idle cycle
    cyc; if_req_valid = 1'b1; if_req_addr = 32'h0000_5008; axi_arready = 1'b1;
    cyc; if_req_valid = 1'b0;
    cyc; axi_arready = 1'b0; if_flush = 1'b1;
    smp; chk("flush rready", 64'(axi_rready), 64'd1);
    cyc; if_flush = 1'b0; axi_rvalid = 1'b1; axi_rdata = 64'h7777_6666_5555_4444;
    smp; chk("flush R handshake", 64'(axi_rready), 64'd1);
    cyc; axi_rvalid = 1'b0; ls_req_valid = 1'b1; ls_req_addr = 32'h0000_6010;
    smp; chk("flush suppressed", 64'(if_resp_valid), 64'd0);
         chk("flush next ls accept", 64'(ls_req_ready), 64'd1);
    cyc; ls_req_valid = 1'b0; axi_arready = 1'b1;
    cyc; axi_arready = 1'b0; axi_rvalid = 1'b1;
    cyc; axi_rvalid = 1'b0;
    smp; chk("post-flush ls resp", 64'(ls_resp_valid), 64'd1);

    // Asynchronous reset in ADDR, then normal fetch
    cyc; if_req_valid = 1'b1; if_req_addr = 32'h0000_7000;
    cyc; if_req_valid = 1'b0;
    chk("pre-reset arvalid", 64'(axi_arvalid), 64'd1);
    #2; rst_n = 1'b0; #1;
    chk("async rst arvalid", 64'(axi_arvalid), 64'd0);
    chk("async rst araddr", 64'(axi_araddr), 64'd0);
    chk("async rst resp_data", resp_data, 64'd0);
    smp;
    cyc; rst_n = 1'b1;
    cyc; if_req_valid = 1'b1; if_req_addr = 32'h0000_7008; axi_arready = 1'b1; axi_rvalid = 1'b1;
    smp; chk("post-reset accept", 64'(if_req_ready), 64'd1);
    cyc; if_req_valid = 1'b0;
    smp; chk("post-reset araddr", 64'(axi_araddr), 64'h7008);
    cyc; cyc;
    smp; chk("post-reset resp", 64'(if_resp_valid), 64'd1);
    cyc; axi_arready = 1'b0; axi_rvalid = 1'b0;

    // Random traffic against a slave with random AR and R stalls
    for (int c = 0; c < 3000; c++) begin
      cyc;
      if_req_valid = ($urandom_range(0, 2) != 0);
      ls_req_valid = ($urandom_range(0, 2) != 0);
      if_req_addr  = $urandom;
      ls_req_addr  = $urandom;
      if_flush     = ($urandom_range(0, 9) == 0);
      axi_arready  = ($urandom_range(0, 2) == 0);
      axi_rvalid   = s_pend && (s_wait == 0);
      axi_rdata    = {$urandom, $urandom};
      axi_rresp    = 2'($urandom_range(0, 3));
      if (s_pend && (s_wait != 0)) s_wait--;
      smp;
      if (if_resp_valid || ls_resp_valid) n_resp++;
      if (axi_arvalid && axi_arready) begin
        s_pend = 1'b1;
        s_wait = $urandom_range(0, 3);
      end else if (axi_rvalid && axi_rready) begin
        s_pend = 1'b0;
      end
    end
    chk("random traffic progressed", 64'(n_resp > 100), 64'd1);

    cyc; if_req_valid = 1'b0; ls_req_valid = 1'b0; if_flush = 1'b0;
    axi_arready = 1'b0; axi_rvalid = 1'b0;
    repeat (2) cyc;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
